// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - mode encodings, pattern reload constants and helpers for led_sequencer
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_SHIFT = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_COUNT = 2'd3
  } mode_t;

  localparam logic [3:0] PAT_SHIFT_INIT = 4'b0001;
  localparam logic [3:0] PAT_BLINK_INIT = 4'b1111;
  localparam logic [3:0] PAT_COUNT_INIT = 4'b0000;

  localparam int PWM_W = 8;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_PASS:  return MODE_SHIFT;
      MODE_SHIFT: return MODE_BLINK;
      MODE_BLINK: return MODE_COUNT;
      MODE_COUNT: return MODE_PASS;
      default:    return MODE_PASS;
    endcase
  endfunction

  // PASS keeps whatever pattern the previous mode left behind.
  function automatic logic [3:0] reload_pat(input mode_t m, input logic [3:0] cur);
    case (m)
      MODE_SHIFT: return PAT_SHIFT_INIT;
      MODE_BLINK: return PAT_BLINK_INIT;
      MODE_COUNT: return PAT_COUNT_INIT;
      default:    return cur;
    endcase
  endfunction

  function automatic logic [3:0] step_pat(input mode_t m, input logic [3:0] pat,
                                          input logic [3:0] sw);
    case (m)
      MODE_SHIFT: return sw[0] ? {pat[0], pat[3:1]} : {pat[2:0], pat[3]};
      MODE_BLINK: return ~pat;
      MODE_COUNT: return sw[3] ? pat : pat + 4'd1;
      default:    return pat;
    endcase
  endfunction

  function automatic logic [3:0] led_value(input mode_t m, input logic [3:0] pat,
                                           input logic [3:0] sw);
    case (m)
      MODE_PASS:  return sw;
      MODE_BLINK: return pat & sw;
      default:    return pat;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer and one-cycle rising-edge pulse
module btn_debounce #(
  parameter int DEB_CYCLES = 1_250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic adv
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          deb;
  logic          deb_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // A new level is accepted only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      deb_d <= deb;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign adv = deb & ~deb_d;

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - four-mode LED sequencer (PASS/SHIFT/BLINK/COUNT) with button mode advance
// Optional global PWM dimming is enabled by defining LED_SEQ_PWM_EN.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV   = 31_250_000,
  parameter int DEB_CYCLES = 1_250_000,
  parameter int PWM_DUTY   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn,
  output logic [3:0] led,
  output logic [1:0] mode
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 2");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("DEB_CYCLES must be at least 1");
  end

  logic [PW-1:0] pcnt;
  logic          tick;
  logic          adv;
  mode_t         mode_q;
  mode_t         mode_nxt;
  logic [3:0]    pat;
  logic [3:0]    led_q;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn),
    .adv  (adv)
  );

  assign tick     = (pcnt == TICK_LAST);
  assign mode_nxt = next_mode(mode_q);

  // Clearing on adv restarts the step phase so every mode begins with a full interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (adv || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // adv takes priority over tick: a mode change never also takes a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_PASS;
      pat    <= '0;
      led_q  <= '0;
    end else begin
      led_q <= led_value(mode_q, pat, sw);
      if (adv) begin
        mode_q <= mode_nxt;
        pat    <= reload_pat(mode_nxt, pat);
      end else if (tick) begin
        pat <= step_pat(mode_q, pat, sw);
      end
    end
  end

  assign mode = mode_q;

`ifdef LED_SEQ_PWM_EN
  localparam logic [PWM_W:0] DUTY = (PWM_W + 1)'(PWM_DUTY);

  if (PWM_DUTY < 0 || PWM_DUTY > 255) begin : g_bad_pwm_duty
    $error("PWM_DUTY must be in 0..255");
  end

  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign led = led_q & {4{({1'b0, pwm_cnt} < DUTY)}};
`else
  localparam int pwm_duty_unused = PWM_DUTY;

  assign led = led_q;
`endif

endmodule
